// File: rtl/reg_timeout_pkg.sv
// Default regbus request/response payloads used when reg_timeout is built without explicit types.
package reg_timeout_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                write;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                valid;
  } reg_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic              ready;
  } reg_rsp_t;

endpackage

// File: rtl/reg_timeout.sv
// Regbus watchdog: forwards transfers unchanged and terminates any transfer whose
// slave has not answered within TIMEOUT_CYCLES, with sticky abort statistics.
module reg_timeout #(
  parameter int          ADDR_WIDTH     = -1,
  parameter int          DATA_WIDTH     = -1,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [63:0] ERR_RDATA      = 64'hBADCAB1E,
  parameter type         reg_req_t      = reg_timeout_pkg::reg_req_t,
  parameter type         reg_rsp_t      = reg_timeout_pkg::reg_rsp_t
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            en_i,
  input  logic                                            clear_i,
  input  reg_req_t                                        reg_req_i,
  output reg_rsp_t                                        reg_rsp_o,
  output reg_req_t                                        reg_req_o,
  input  reg_rsp_t                                        reg_rsp_i,
  output logic                                            timeout_o,
  output logic [7:0]                                      timeout_cnt_o,
  output logic [((ADDR_WIDTH > 0) ? ADDR_WIDTH : 1)-1:0]  timeout_addr_o
);

  localparam int unsigned AW = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;
  localparam int unsigned DW = (DATA_WIDTH > 0) ? DATA_WIDTH : 32;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ABORT = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          wait_c;

  assign wait_c = en_i && reg_req_i.valid && !reg_rsp_i.ready;

  // Next state, wait counter and the (combinational) bus paths.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    reg_req_o = reg_req_i;
    reg_rsp_o = reg_rsp_i;
    case (state_q)
      IDLE: begin
        if (wait_c) begin
          if (wcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = ABORT;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end else begin
          wcnt_d = '0;
        end
      end
      ABORT: begin
        // Slave response is discarded here, even a late ready.
        reg_req_o.valid = 1'b0;
        reg_rsp_o.ready = 1'b1;
        reg_rsp_o.error = 1'b1;
        reg_rsp_o.rdata = DW'(ERR_RDATA);
        wcnt_d          = '0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // State, counter and abort pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      timeout_o <= (state_d == ABORT);
    end
  end

  // Sticky statistics; an abort coinciding with clear restarts the count at one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_cnt_o  <= '0;
      timeout_addr_o <= '0;
    end else if (state_q == ABORT) begin
      timeout_addr_o <= AW'(reg_req_i.addr);
      if (clear_i) begin
        timeout_cnt_o <= 8'd1;
      end else if (timeout_cnt_o != 8'hFF) begin
        timeout_cnt_o <= timeout_cnt_o + 8'd1;
      end
    end else if (clear_i) begin
      timeout_cnt_o <= '0;
    end
  end

endmodule

// File: tb/tb_reg_timeout.sv
// Bench for reg_timeout: two instances (T=16 and T=1) share stimulus and are
// checked every cycle against a transfer-level reference model.
module tb_reg_timeout;
  import reg_timeout_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic en, clr;
  reg_req_t req_i;
  reg_rsp_t rsp_i;
  reg_req_t [1:0]      req_o;
  reg_rsp_t [1:0]      rsp_o;
  logic [1:0]          tmo;
  logic [1:0][7:0]     cnt;
  logic [1:0][31:0]    taddr;

  int tests = 0;
  int fails = 0;

  // reference model: consecutive wait cycles, abort-this-cycle flag, statistics
  int          tv[2];
  int          waited[2];
  bit          ab[2];
  int          mcnt[2];
  logic [31:0] maddr[2];

  always #5 clk = ~clk;

  reg_timeout #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16),
                .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr),
    .reg_req_i(req_i), .reg_rsp_o(rsp_o[0]), .reg_req_o(req_o[0]), .reg_rsp_i(rsp_i),
    .timeout_o(tmo[0]), .timeout_cnt_o(cnt[0]), .timeout_addr_o(taddr[0]));

  reg_timeout #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(1),
                .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clr),
    .reg_req_i(req_i), .reg_rsp_o(rsp_o[1]), .reg_req_o(req_o[1]), .reg_rsp_i(rsp_i),
    .timeout_o(tmo[1]), .timeout_cnt_o(cnt[1]), .timeout_addr_o(taddr[1]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      waited[i] = 0; ab[i] = 1'b0; mcnt[i] = 0; maddr[i] = '0;
    end
  endtask

  task automatic check_cycle();
    reg_req_t ereq;
    reg_rsp_t ersp;
    for (int i = 0; i < 2; i++) begin
      ereq = req_i;
      ersp = rsp_i;
      if (ab[i]) begin
        ereq.valid = 1'b0;
        ersp.rdata = 32'hBADCAB1E;
        ersp.error = 1'b1;
        ersp.ready = 1'b1;
      end
      chk($sformatf("req_o[%0d]", i), 128'(req_o[i]), 128'(ereq));
      chk($sformatf("rsp_o[%0d]", i), 128'(rsp_o[i]), 128'(ersp));
      chk($sformatf("timeout_o[%0d]", i), 128'(tmo[i]), 128'(ab[i]));
      chk($sformatf("timeout_cnt[%0d]", i), 128'(cnt[i]), 128'(mcnt[i]));
      chk($sformatf("timeout_addr[%0d]", i), 128'(taddr[i]), 128'(maddr[i]));
    end
  endtask

  task automatic advance();
    for (int i = 0; i < 2; i++) begin
      if (ab[i]) begin
        ab[i] = 1'b0;
        waited[i] = 0;
        mcnt[i] = clr ? 1 : ((mcnt[i] >= 255) ? 255 : mcnt[i] + 1);
        maddr[i] = req_i.addr;
      end else begin
        if (clr) mcnt[i] = 0;
        if (en && req_i.valid && !rsp_i.ready) begin
          waited[i]++;
          if (waited[i] >= tv[i]) begin
            ab[i] = 1'b1;
            waited[i] = 0;
          end
        end else begin
          waited[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    #3;
    check_cycle();
    advance();
    @(posedge clk);
    #1;
  endtask

  // One upstream transfer; the slave answers at cycle lat (-1 = never).
  task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d, input int lat,
                      input int en_from, input int en_to, input bit clr_abort, input bit rnd_clr,
                      output int done_k, output bit done_err);
    bit end_now;
    done_k = -1;
    done_err = 1'b0;
    for (int k = 0; k < 200; k++) begin
      req_i.addr = a; req_i.write = w; req_i.wdata = d; req_i.wstrb = 4'hF; req_i.valid = 1'b1;
      rsp_i.ready = (k == lat);
      rsp_i.rdata = (k == lat) ? (32'h1234 ^ a) : 32'h0;
      rsp_i.error = 1'b0;
      en  = !(k >= en_from && k < en_to);
      clr = (clr_abort && ab[0]) || (rnd_clr && ($urandom_range(0, 9) == 0));
      end_now = ab[0] || rsp_i.ready;
      if (end_now) begin
        done_k = k;
        done_err = ab[0];
      end
      step();
      if (end_now) break;
    end
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;
    rsp_i.rdata = '0;
    en = 1'b1;
    clr = 1'b0;
  endtask

  initial begin
    int  k;
    bit  e;
    int  first_tmo;
    int  lat;
    bit  xen;
    tv[0] = 16;
    tv[1] = 1;
    rst_n = 1'b0;
    en = 1'b1;
    clr = 1'b0;
    req_i = '0;
    rsp_i = '0;
    reset_model();
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      #3; check_cycle(); reset_model(); @(posedge clk); #1;
    end
    rst_n = 1'b1;
    step();

    // read with slave ready at cycle 3
    xfer(32'h40, 1'b0, 32'h0, 3, 0, 0, 1'b0, 1'b0, k, e);
    chk("read_done_cycle", 128'(k), 128'(3));
    chk("read_no_error", 128'(e), 128'(0));

    // write to a hung slave
    xfer(32'h80, 1'b1, 32'hCAFE, -1, 0, 0, 1'b0, 1'b0, k, e);
    chk("hung_abort_cycle", 128'(k), 128'(16));
    chk("hung_error", 128'(e), 128'(1));
    chk("hung_addr", 128'(taddr[0]), 128'(32'h80));
    chk("hung_cnt", 128'(cnt[0]), 128'(1));

    // ready on the last legal cycle, then a fresh count back-to-back
    xfer(32'h44, 1'b0, 32'h0, 15, 0, 0, 1'b0, 1'b0, k, e);
    chk("edge_done_cycle", 128'(k), 128'(15));
    chk("edge_no_error", 128'(e), 128'(0));
    xfer(32'hC0, 1'b0, 32'h0, -1, 0, 0, 1'b0, 1'b0, k, e);
    chk("b2b_abort_cycle", 128'(k), 128'(16));

    // late ready in the abort cycle is ignored
    xfer(32'hC4, 1'b0, 32'h0, 16, 0, 0, 1'b0, 1'b0, k, e);
    chk("late_ready_abort", 128'(e), 128'(1));
    chk("late_ready_cnt", 128'(cnt[0]), 128'(3));

    // watchdog disabled: slow slave completes without error
    xfer(32'h48, 1'b0, 32'h0, 40, 0, 1000, 1'b0, 1'b0, k, e);
    chk("dis_done_cycle", 128'(k), 128'(40));
    chk("dis_no_error", 128'(e), 128'(0));
    chk("dis_cnt", 128'(cnt[0]), 128'(3));

    // enable dropped mid-wait restarts the count
    xfer(32'h4C, 1'b0, 32'h0, -1, 8, 30, 1'b0, 1'b0, k, e);
    chk("reen_abort_cycle", 128'(k), 128'(46));

    // reset at cycle 10 of a stuck transfer
    req_i = '0; req_i.addr = 32'hD0; req_i.valid = 1'b1; req_i.wstrb = 4'hF;
    for (int c = 0; c < 10; c++) step();
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_cycle();
    @(posedge clk); #1;
    req_i.valid = 1'b0;
    #3; check_cycle(); reset_model(); @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    first_tmo = -1;
    req_i.addr = 32'hD4; req_i.valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (tmo[0] && first_tmo < 0) first_tmo = c;
      check_cycle();
      if (ab[0]) begin
        advance(); @(posedge clk); #1;
        break;
      end
      advance(); @(posedge clk); #1;
    end
    req_i.valid = 1'b0;
    chk("post_reset_abort_cycle", 128'(first_tmo), 128'(16));
    chk("post_reset_cnt", 128'(cnt[0]), 128'(1));

    // saturation and clear-with-abort
    for (int n = 0; n < 256; n++) xfer(32'h100 + 32'(n), 1'b0, 32'h0, -1, 0, 0, 1'b0, 1'b0, k, e);
    chk("sat_cnt", 128'(cnt[0]), 128'(255));
    xfer(32'hE0, 1'b1, 32'h5, -1, 0, 0, 1'b1, 1'b0, k, e);
    chk("clear_abort_cnt", 128'(cnt[0]), 128'(1));
    chk("clear_abort_addr", 128'(taddr[0]), 128'(32'hE0));

    // randomized transfers against the model
    for (int n = 0; n < 60; n++) begin
      xen = ($urandom_range(0, 6) != 0);
      lat = xen ? (int'($urandom_range(0, 24)) - 1) : int'($urandom_range(0, 24));
      xfer($urandom & 32'hFFFC, 1'($urandom), $urandom, lat, 0, xen ? 0 : 1000, 1'b0, 1'b1, k, e);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
